// File: rtl/scaler9999_to_8.sv
// Sequential restoring-division scaler mapping a 0..IN_MAX decimal value to a 0..OUT_MAX code.
// Optional build macro REV_SCALER_FASTPATH_EN short-circuits the exact endpoints (0 and IN_MAX).
module scaler9999_to_8 #(
  parameter int unsigned IN_MAX  = 9999,
  parameter int unsigned OUT_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] value,
  output logic        busy,
  output logic        done,
  output logic [7:0]  code8,
  output logic        clamped
);

  localparam int unsigned VAL_W = 16;
  localparam int unsigned NUM_W = $clog2(IN_MAX * OUT_MAX + IN_MAX / 2 + 1);
  localparam int unsigned REM_W = $clog2(IN_MAX) + 1;
  localparam int unsigned CNT_W = $clog2(NUM_W);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DIV,
    DONE
  } state_t;

  state_t             state;
  logic [VAL_W-1:0]   value_q;
  logic [NUM_W-1:0]   num_q;
  logic [REM_W-1:0]   rem_q;
  logic [7:0]         quo_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               clamp_q;

  logic               clamp_c;
  logic [VAL_W-1:0]   v_c;
  logic [NUM_W-1:0]   num_c;
  logic [REM_W-1:0]   rem_shift_c;
  logic               rem_ge_c;
  logic [REM_W-1:0]   rem_next_c;
  logic               fast_c;
  logic [7:0]         fast_code_c;

  // Saturation, rounded numerator and one restoring-division step.
  always_comb begin
    clamp_c     = 1'b0;
    v_c         = '0;
    num_c       = '0;
    rem_shift_c = '0;
    rem_ge_c    = 1'b0;
    rem_next_c  = '0;
    fast_c      = 1'b0;
    fast_code_c = '0;

    clamp_c     = (value_q > VAL_W'(IN_MAX));
    v_c         = clamp_c ? VAL_W'(IN_MAX) : value_q;
    num_c       = NUM_W'(v_c) * NUM_W'(OUT_MAX) + NUM_W'(IN_MAX / 2);

    // Remainder stays below IN_MAX, so its top bit is always free for the shift.
    rem_shift_c = {rem_q[REM_W-2:0], num_q[NUM_W-1]};
    rem_ge_c    = (rem_shift_c >= REM_W'(IN_MAX));
    rem_next_c  = rem_ge_c ? (rem_shift_c - REM_W'(IN_MAX)) : rem_shift_c;

`ifdef REV_SCALER_FASTPATH_EN
    fast_c      = (v_c == '0) || (v_c == VAL_W'(IN_MAX));
    fast_code_c = (v_c == '0) ? 8'd0 : 8'(OUT_MAX);
`else
    fast_c      = 1'b0;
    fast_code_c = 8'd0;
`endif
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      value_q <= '0;
      num_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      clamp_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      code8   <= '0;
      clamped <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            value_q <= value;
            busy    <= 1'b1;
            state   <= LOAD;
          end
        end

        LOAD: begin
          clamp_q <= clamp_c;
          num_q   <= num_c;
          rem_q   <= '0;
          cnt_q   <= CNT_W'(NUM_W - 1);
          if (fast_c) begin
            quo_q <= fast_code_c;
            state <= DONE;
          end else begin
            quo_q <= '0;
            state <= DIV;
          end
        end

        DIV: begin
          // Quotient never exceeds OUT_MAX, so bits shifted past bit 7 are zero.
          rem_q <= rem_next_c;
          quo_q <= {quo_q[6:0], rem_ge_c};
          num_q <= {num_q[NUM_W-2:0], 1'b0};
          if (cnt_q == '0) begin
            state <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        DONE: begin
          code8   <= quo_q;
          clamped <= clamp_q;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scaler9999_to_8.sv
// Directed self-checking bench for scaler9999_to_8 (latency, rounding, clamping, handshake, reset abort).
module tb_scaler9999_to_8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] value;
  logic        busy;
  logic        done;
  logic [7:0]  code8;
  logic        clamped;

  int n_checks;
  int n_pass;

  scaler9999_to_8 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .value   (value),
    .busy    (busy),
    .done    (done),
    .code8   (code8),
    .clamped (clamped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one edge (E0); returns at the falling edge just after E0.
  task automatic do_start(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    value = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges after E0 until done is seen; lat = k means done after edge E0+k.
  task automatic wait_done(output int lat, output bit ok);
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i <= 100; i++) begin
      if (done) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({busy, done, code8, clamped} !== 11'd0) begin
      $display("FAIL reset_state: busy=%0b done=%0b code8=%0d clamped=%0b, want all 0", busy, done, code8, clamped);
    end else n_pass++;
  endtask

  task automatic test_latency;
    int busy_cnt;
    int lat;
    bit ok;
    busy_cnt = 0;
    lat = 0;
    ok = 1'b0;
    do_start(16'd5000);
    for (int i = 0; i <= 100; i++) begin
      if (done) begin
        lat = i;
        ok  = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (!ok || lat != 24) $display("FAIL latency_5000: done after edge E0+%0d (seen=%0b), want E0+24", lat, ok);
    else n_pass++;
    n_checks++;
    if (busy_cnt != 24 || busy !== 1'b0) $display("FAIL busy_window: busy cycles=%0d busy_at_done=%0b, want 24 and 0", busy_cnt, busy);
    else n_pass++;
    n_checks++;
    if (code8 !== 8'd128 || clamped !== 1'b0) $display("FAIL code_5000: code8=%0d clamped=%0b, want 128 0", code8, clamped);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || code8 !== 8'd128) $display("FAIL done_pulse_width: done=%0b code8=%0d, want 0 128", done, code8);
    else n_pass++;
  endtask

  task automatic test_rounding;
    logic [15:0] vin [4];
    logic [7:0]  exp [4];
    int lat;
    bit ok;
    vin = '{16'd0, 16'd19, 16'd20, 16'd9999};
    exp = '{8'd0, 8'd0, 8'd1, 8'd255};
    for (int k = 0; k < 4; k++) begin
      do_start(vin[k]);
      wait_done(lat, ok);
      n_checks++;
      if (!ok || code8 !== exp[k] || clamped !== 1'b0)
        $display("FAIL round_%0d: code8=%0d clamped=%0b seen=%0b, want %0d 0", vin[k], code8, clamped, ok, exp[k]);
      else n_pass++;
    end
  endtask

  task automatic test_clamp;
    int lat;
    bit ok;
    do_start(16'd12345);
    wait_done(lat, ok);
    n_checks++;
    if (!ok || code8 !== 8'd255 || clamped !== 1'b1) $display("FAIL clamp_12345: code8=%0d clamped=%0b, want 255 1", code8, clamped);
    else n_pass++;
    do_start(16'd39);
    wait_done(lat, ok);
    n_checks++;
    if (!ok || code8 !== 8'd1 || clamped !== 1'b0) $display("FAIL after_clamp_39: code8=%0d clamped=%0b, want 1 0", code8, clamped);
    else n_pass++;
    do_start(16'hFFFF);
    wait_done(lat, ok);
    n_checks++;
    if (!ok || code8 !== 8'd255 || clamped !== 1'b1) $display("FAIL clamp_65535: code8=%0d clamped=%0b, want 255 1", code8, clamped);
    else n_pass++;
  endtask

  task automatic test_ignore_start;
    int dones;
    dones = 0;
    do_start(16'd5000);
    for (int i = 1; i < 60; i++) begin
      if (i == 4) begin
        start = 1'b1;
        value = 16'd100;
      end else if (i == 5) begin
        start = 1'b0;
        value = 16'd7777;
      end
      if (done) begin
        dones++;
        n_checks++;
        if (code8 !== 8'd128) $display("FAIL ignore_start_code: code8=%0d, want 128", code8);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (dones != 1) $display("FAIL ignore_start_dones: done pulses=%0d, want 1", dones);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int lat;
    bit ok;
    do_start(16'd5000);
    wait_done(lat, ok);
    start = 1'b1;
    value = 16'd1000;
    @(negedge clk);
    start = 1'b0;
    value = 16'd3;
    n_checks++;
    if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%0b after start in done cycle, want 1", busy);
    else n_pass++;
    wait_done(lat, ok);
    n_checks++;
    if (!ok || lat != 24 || code8 !== 8'd26) $display("FAIL b2b_result: lat=%0d code8=%0d seen=%0b, want 24 26", lat, code8, ok);
    else n_pass++;
  endtask

  task automatic test_reset_abort;
    int dones;
    int lat;
    bit ok;
    dones = 0;
    do_start(16'd5000);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || code8 !== 8'd0 || clamped !== 1'b0)
      $display("FAIL abort_state: busy=%0b done=%0b code8=%0d clamped=%0b, want 0 0 0 0", busy, done, code8, clamped);
    else n_pass++;
    for (int i = 0; i < 30; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones != 0) $display("FAIL abort_no_done: done pulses=%0d, want 0", dones);
    else n_pass++;
    do_start(16'd39);
    wait_done(lat, ok);
    n_checks++;
    if (!ok || lat != 24 || code8 !== 8'd1) $display("FAIL after_abort: lat=%0d code8=%0d seen=%0b, want 24 1", lat, code8, ok);
    else n_pass++;
  endtask

  task automatic test_roundtrip;
    int fwd;
    int lat;
    bit ok;
    int bad;
    bad = 0;
    for (int c = 0; c < 256; c++) begin
      fwd = (c * 9999 + 127) / 255;
      do_start(16'(fwd));
      wait_done(lat, ok);
      n_checks++;
      if (!ok || code8 !== 8'(c)) begin
        $display("FAIL roundtrip_%0d: value=%0d code8=%0d seen=%0b, want %0d", c, fwd, code8, ok, c);
        bad++;
      end else n_pass++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL roundtrip_total: %0d codes differ, want 0", bad);
    else n_pass++;
  endtask

  task automatic test_fastpath;
    logic [15:0] vin [3];
    int exp_lat [3];
    int lat;
    bit ok;
    vin = '{16'd0, 16'd9999, 16'd5000};
`ifdef REV_SCALER_FASTPATH_EN
    exp_lat = '{2, 2, 24};
`else
    exp_lat = '{24, 24, 24};
`endif
    for (int k = 0; k < 3; k++) begin
      do_start(vin[k]);
      wait_done(lat, ok);
      n_checks++;
      if (!ok || lat != exp_lat[k]) $display("FAIL latency_%0d: done after E0+%0d seen=%0b, want E0+%0d", vin[k], lat, ok, exp_lat[k]);
      else n_pass++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    value    = '0;
    test_reset;
    test_latency;
    test_rounding;
    test_clamp;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    test_roundtrip;
    test_fastpath;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
